match_run_tracker: RTL and testbench

- Downstream consumer of the operand comparator's per-beat match result.
- Accumulates match statistics over a framed stream of compare beats: total matches, longest consecutive run, and index of the first match.
- Pulses an event when a run reaches a threshold.
- Reports a per-frame result record over a valid/ready handshake to the scoreboard/control side.

---
 rtl/match_run_tracker_pkg.sv | 21 ++
 rtl/match_run_tracker_if.sv | 29 ++
 rtl/match_run_tracker_sat_counter.sv | 21 ++
 rtl/match_run_tracker.sv | 110 +++++++++++
 tb/tb_match_run_tracker.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/match_run_tracker_pkg.sv
// Shared types for the match run tracker: FSM state encoding, result record
// and the default threshold.
package match_run_tracker_pkg;

   localparam int CNT_BW_DEF     = 16;
   localparam int RUN_THRESH_DEF = 4;

   typedef enum logic [1:0] {
      TRK_IDLE   = 2'd0,
      TRK_ACTIVE = 2'd1,
      TRK_REPORT = 2'd2
   } trk_state_e;

   typedef struct packed {
      logic                  found;
      logic [CNT_BW_DEF-1:0] total;
      logic [CNT_BW_DEF-1:0] longest;
      logic [CNT_BW_DEF-1:0] first_idx;
   } trk_res_t;

endpackage

// File: rtl/match_run_tracker_if.sv
// Beat stream in, per-frame result record out (valid/ready), plus status.
interface match_run_tracker_if #(
   parameter int CNT_BW = 16
);
   logic              start_i;
   logic              valid_i;
   logic              match_i;
   logic              last_i;
   logic              ready_i;
   logic              busy_o;
   logic              hit_o;
   logic              res_valid_o;
   logic              res_found_o;
   logic [CNT_BW-1:0] res_total_o;
   logic [CNT_BW-1:0] res_longest_o;
   logic [CNT_BW-1:0] res_first_idx_o;

   modport slave (
      input  start_i, valid_i, match_i, last_i, ready_i,
      output busy_o, hit_o, res_valid_o, res_found_o,
             res_total_o, res_longest_o, res_first_idx_o
   );

   modport master (
      output start_i, valid_i, match_i, last_i, ready_i,
      input  busy_o, hit_o, res_valid_o, res_found_o,
             res_total_o, res_longest_o, res_first_idx_o
   );
endinterface

// File: rtl/match_run_tracker_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_BW = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_clr,
   input  logic              i_inc,
   output logic [CNT_BW-1:0] o_cnt
);
   logic [CNT_BW-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (reset || i_clr)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != {CNT_BW{1'b1}}))
         r_cnt <= r_cnt + CNT_BW'(1);
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/match_run_tracker.sv
// Per-frame match statistics over a compare-beat stream: total, longest run,
// first match index, plus a threshold pulse on the current run.
module match_run_tracker
   import match_run_tracker_pkg::*;
#(
   parameter int CNT_BW     = CNT_BW_DEF,
   parameter int RUN_THRESH = RUN_THRESH_DEF
) (
   input  logic               clock,
   input  logic               reset,
   match_run_tracker_if.slave bus
);
   localparam logic [1:0]        ST_IDLE   = 2'(TRK_IDLE);
   localparam logic [1:0]        ST_ACTIVE = 2'(TRK_ACTIVE);
   localparam logic [1:0]        ST_REPORT = 2'(TRK_REPORT);
   localparam logic [CNT_BW-1:0] CNT_MAX   = {CNT_BW{1'b1}};
   localparam logic [CNT_BW-1:0] THR       = CNT_BW'(RUN_THRESH);

   logic [1:0]        r_state;
   logic              r_found, r_hit;
   logic [CNT_BW-1:0] r_longest, r_first_idx;
   logic              r_res_valid, r_res_found;
   logic [CNT_BW-1:0] r_res_total, r_res_longest, r_res_first_idx;

   logic              w_start, w_beat, w_mbeat;
   logic [CNT_BW-1:0] w_idx, w_run, w_total;
   logic [CNT_BW-1:0] w_run_nx, w_total_nx, w_longest_nx, w_first_nx;
   logic              w_found_nx;

   // Start wins over any same-cycle beat; REPORT ignores the stream entirely.
   assign w_start = bus.start_i && (r_state != ST_REPORT);
   assign w_beat  = (r_state == ST_ACTIVE) && bus.valid_i && !bus.start_i;
   assign w_mbeat = w_beat && bus.match_i;

   sat_counter #(.CNT_BW(CNT_BW)) u_idx (
      .clock(clock), .reset(reset), .i_clr(w_start), .i_inc(w_beat), .o_cnt(w_idx)
   );
   sat_counter #(.CNT_BW(CNT_BW)) u_run (
      .clock(clock), .reset(reset), .i_clr(w_start || (w_beat && !bus.match_i)),
      .i_inc(w_mbeat), .o_cnt(w_run)
   );
   sat_counter #(.CNT_BW(CNT_BW)) u_total (
      .clock(clock), .reset(reset), .i_clr(w_start), .i_inc(w_mbeat), .o_cnt(w_total)
   );

   // Post-beat views, so the result record can be taken on the last beat itself.
   assign w_run_nx     = (w_run == CNT_MAX) ? w_run : w_run + CNT_BW'(1);
   assign w_total_nx   = (w_mbeat && (w_total != CNT_MAX)) ? w_total + CNT_BW'(1) : w_total;
   assign w_found_nx   = r_found || w_mbeat;
   assign w_first_nx   = (w_mbeat && !r_found) ? w_idx : r_first_idx;
   assign w_longest_nx = (w_mbeat && (w_run_nx > r_longest)) ? w_run_nx : r_longest;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state         <= ST_IDLE;
         r_found         <= 1'b0;
         r_hit           <= 1'b0;
         r_longest       <= '0;
         r_first_idx     <= '0;
         r_res_valid     <= 1'b0;
         r_res_found     <= 1'b0;
         r_res_total     <= '0;
         r_res_longest   <= '0;
         r_res_first_idx <= '0;
      end else begin
         // A run saturated at CNT_MAX no longer changes, so it cannot re-fire.
         // The last beat leads straight to REPORT, where hit must stay low.
         r_hit <= w_mbeat && !bus.last_i && (w_run != CNT_MAX) && (w_run_nx == THR);

         if (w_start) begin
            r_found     <= 1'b0;
            r_longest   <= '0;
            r_first_idx <= '0;
         end else if (w_beat) begin
            r_found     <= w_found_nx;
            r_longest   <= w_longest_nx;
            r_first_idx <= w_first_nx;
         end

         case (r_state)
            ST_IDLE:
               if (bus.start_i) r_state <= ST_ACTIVE;
            ST_ACTIVE:
               if (w_beat && bus.last_i) begin
                  r_state         <= ST_REPORT;
                  r_res_valid     <= 1'b1;
                  r_res_found     <= w_found_nx;
                  r_res_total     <= w_total_nx;
                  r_res_longest   <= w_longest_nx;
                  r_res_first_idx <= w_first_nx;
               end
            ST_REPORT:
               if (bus.ready_i) begin
                  r_state     <= ST_IDLE;
                  r_res_valid <= 1'b0;
               end
            default:
               r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy_o          = (r_state != ST_IDLE);
   assign bus.hit_o           = r_hit;
   assign bus.res_valid_o     = r_res_valid;
   assign bus.res_found_o     = r_res_found;
   assign bus.res_total_o     = r_res_total;
   assign bus.res_longest_o   = r_res_longest;
   assign bus.res_first_idx_o = r_res_first_idx;
endmodule

// File: tb/tb_match_run_tracker.sv
// Two trackers (16-bit and 4-bit counters, threshold 4) fed the same stream,
// checked against a behavioural model and a result scoreboard per instance.
module tb_match_run_tracker;
   import match_run_tracker_pkg::*;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   match_run_tracker_if #(.CNT_BW(16)) b16();
   match_run_tracker_if #(.CNT_BW(4))  b4();

   match_run_tracker #(.CNT_BW(16), .RUN_THRESH(4)) u_dut16 (
      .clock(clock), .reset(reset), .bus(b16.slave)
   );
   match_run_tracker #(.CNT_BW(4), .RUN_THRESH(4)) u_dut4 (
      .clock(clock), .reset(reset), .bus(b4.slave)
   );

   localparam int THR = 4;
   int MAXV[2] = '{65535, 15};

   int n_tests = 0;
   int n_fail  = 0;

   trk_state_e m_st[2];
   int         m_idx[2], m_run[2], m_tot[2], m_long[2], m_first[2];
   bit         m_found[2];
   bit         e_hit[2];
   bit         prev_v[2];
   int         hit_cnt[2];
   trk_res_t   cur[2];
   trk_res_t   q0[$];
   trk_res_t   q1[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_k(input int k);
      m_idx[k] = 0; m_run[k] = 0; m_tot[k] = 0;
      m_long[k] = 0; m_first[k] = 0; m_found[k] = 1'b0;
   endtask

   task automatic model_step(input bit rst, input bit s, input bit v,
                             input bit m, input bit l, input bit r);
      trk_res_t res;
      for (int k = 0; k < 2; k++) begin
         e_hit[k] = 1'b0;
         if (rst) begin
            m_st[k] = TRK_IDLE;
            clr_k(k);
            cur[k] = '0;
            prev_v[k] = 1'b0;
            if (k == 0) q0.delete(); else q1.delete();
         end else begin
            case (m_st[k])
               TRK_IDLE:
                  if (s) begin clr_k(k); m_st[k] = TRK_ACTIVE; end
               TRK_ACTIVE:
                  if (s) clr_k(k);
                  else if (v) begin
                     if (m) begin
                        if (m_run[k] < MAXV[k]) begin
                           m_run[k]++;
                           if (m_run[k] == THR && !l) e_hit[k] = 1'b1;
                        end
                        if (m_tot[k] < MAXV[k]) m_tot[k]++;
                        if (!m_found[k]) begin m_first[k] = m_idx[k]; m_found[k] = 1'b1; end
                        if (m_run[k] > m_long[k]) m_long[k] = m_run[k];
                     end else
                        m_run[k] = 0;
                     if (m_idx[k] < MAXV[k]) m_idx[k]++;
                     if (l) begin
                        res.found     = m_found[k];
                        res.total     = 16'(m_tot[k]);
                        res.longest   = 16'(m_long[k]);
                        res.first_idx = 16'(m_first[k]);
                        if (k == 0) q0.push_back(res); else q1.push_back(res);
                        m_st[k] = TRK_REPORT;
                     end
                  end
               TRK_REPORT:
                  if (r) m_st[k] = TRK_IDLE;
               default: m_st[k] = TRK_IDLE;
            endcase
         end
      end
   endtask

   task automatic check_outputs();
      logic [3:0]  ob;
      logic [15:0] ot, ol, of;
      int          sz;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            ob = {b16.busy_o, b16.hit_o, b16.res_valid_o, b16.res_found_o};
            ot = b16.res_total_o; ol = b16.res_longest_o; of = b16.res_first_idx_o;
         end else begin
            ob = {b4.busy_o, b4.hit_o, b4.res_valid_o, b4.res_found_o};
            ot = {12'b0, b4.res_total_o}; ol = {12'b0, b4.res_longest_o};
            of = {12'b0, b4.res_first_idx_o};
         end
         if (ob[2] === 1'b1) hit_cnt[k]++;
         chk($sformatf("busy%0d", k), 32'(ob[3]), 32'(m_st[k] != TRK_IDLE));
         chk($sformatf("hit%0d", k), 32'(ob[2]), 32'(e_hit[k]));
         chk($sformatf("res_valid%0d", k), 32'(ob[1]), 32'(m_st[k] == TRK_REPORT));
         if (ob[1] === 1'b1 && !prev_v[k]) begin
            sz = (k == 0) ? q0.size() : q1.size();
            chk($sformatf("sb_pop%0d", k), 32'(sz > 0), 32'd1);
            if (sz > 0) begin
               if (k == 0) cur[0] = q0.pop_front();
               else        cur[1] = q1.pop_front();
            end
         end
         prev_v[k] = (ob[1] === 1'b1);
         chk($sformatf("found%0d", k), 32'(ob[0]), 32'(cur[k].found));
         chk($sformatf("total%0d", k), 32'(ot), 32'(cur[k].total));
         chk($sformatf("longest%0d", k), 32'(ol), 32'(cur[k].longest));
         chk($sformatf("first_idx%0d", k), 32'(of), 32'(cur[k].first_idx));
      end
   endtask

   task automatic step(input bit rst, input bit s, input bit v,
                       input bit m, input bit l, input bit r);
      @(negedge clock);
      check_outputs();
      reset = rst;
      b16.start_i = s; b16.valid_i = v; b16.match_i = m; b16.last_i = l; b16.ready_i = r;
      b4.start_i  = s; b4.valid_i  = v; b4.match_i  = m; b4.last_i  = l; b4.ready_i  = r;
      model_step(rst, s, v, m, l, r);
   endtask

   // Start, then n beats taken from pat (bit i = beat i), last on the final beat.
   task automatic run_frame(input logic [31:0] pat, input int n, input bit rdy);
      step(0, 1, 0, 0, 0, rdy);
      for (int i = 0; i < n; i++)
         step(0, 0, 1, pat[i], (i == n - 1), rdy);
   endtask

   initial begin
      reset = 1'b1;
      b16.start_i = 0; b16.valid_i = 0; b16.match_i = 0; b16.last_i = 0; b16.ready_i = 0;
      b4.start_i  = 0; b4.valid_i  = 0; b4.match_i  = 0; b4.last_i  = 0; b4.ready_i  = 0;
      model_step(1, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clock);

      // Reset held while inputs toggle randomly, including start_i.
      for (int i = 0; i < 6; i++)
         step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      // Mixed pattern 1,1,0,1,1,1,1,0: one hit after beat 7.
      hit_cnt = '{0, 0};
      run_frame(32'h0000_007B, 8, 1'b0);
      step(0, 0, 0, 0, 0, 0);
      chk("pat_total", 32'(b16.res_total_o), 32'd6);
      chk("pat_longest", 32'(b16.res_longest_o), 32'd4);
      chk("pat_first", 32'(b16.res_first_idx_o), 32'd0);
      chk("pat_found", 32'(b16.res_found_o), 32'd1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("pat_hits16", 32'(hit_cnt[0]), 32'd1);
      chk("pat_hits4", 32'(hit_cnt[1]), 32'd1);

      // No matches at all.
      hit_cnt = '{0, 0};
      run_frame(32'h0, 5, 1'b1);
      step(0, 0, 0, 0, 0, 1);
      chk("none_found", 32'(b16.res_found_o), 32'd0);
      chk("none_total", 32'(b16.res_total_o), 32'd0);
      chk("none_hits", 32'(hit_cnt[0]), 32'd0);

      // Backpressure: result held while start/valid are ignored.
      run_frame(32'h4, 3, 1'b0);
      for (int i = 0; i < 10; i++)
         step(0, i[0], !i[0], 1, i[1], 0);
      chk("bp_first", 32'(b16.res_first_idx_o), 32'd2);
      chk("bp_total", 32'(b16.res_total_o), 32'd1);
      chk("bp_busy", 32'(b16.busy_o), 32'd1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // 20 straight matches: 4-bit instance saturates at 15, hit fires once.
      hit_cnt = '{0, 0};
      run_frame(32'h000F_FFFF, 21, 1'b1);
      step(0, 0, 0, 0, 0, 1);
      chk("sat_total4", 32'(b4.res_total_o), 32'd15);
      chk("sat_longest4", 32'(b4.res_longest_o), 32'd15);
      chk("sat_total16", 32'(b16.res_total_o), 32'd20);
      chk("sat_hits4", 32'(hit_cnt[1]), 32'd1);
      chk("sat_hits16", 32'(hit_cnt[0]), 32'd1);

      // Reset mid-frame, then a fresh 2-match frame.
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      run_frame(32'h3, 2, 1'b1);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_total", 32'(b16.res_total_o), 32'd2);
      chk("rst_first", 32'(b16.res_first_idx_o), 32'd0);

      // Restart collides with a last beat: beat dropped, frame stays open.
      step(0, 1, 0, 0, 0, 1);
      step(0, 0, 1, 1, 0, 1);
      step(0, 1, 1, 1, 1, 1);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("restart_novalid", 32'(b16.res_valid_o), 32'd0);
      chk("restart_busy", 32'(b16.busy_o), 32'd1);
      step(0, 0, 1, 0, 1, 1);

      // Random traffic, model and scoreboard keep checking every cycle.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
              1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
              1'($urandom));
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
      chk("sb_drain0", 32'(q0.size()), 32'd0);
      chk("sb_drain1", 32'(q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
